// File: rtl/latch_write_arbiter.sv
// rtl/latch_write_arbiter.sv - round-robin arbiter and setup/open/close write sequencer for a shared D-latch
module latch_write_arbiter #(
  parameter int WIRE     = 8,
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int OPEN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIRE-1:0] data,
  output logic [NREQ-1:0]      ack,
  output logic [WIRE-1:0]      latch_d,
  output logic                 latch_en,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_t;

  state_t          state;
  logic [IDW-1:0]  last;
  logic [CW-1:0]   cnt;
  logic            found;
  logic [IDW-1:0]  winner;
  logic [WIRE-1:0] win_data;

  assign busy = (state != IDLE);

  // Round-robin scan starting just after the last served requester; the
  // descending loop lets the nearest asserted request overwrite farther ones.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        found    = 1'b1;
        winner   = IDW'(idx);
        win_data = data[idx*WIRE +: WIRE];
      end
    end
  end

  // Sequencer: capture data only in IDLE, hold it stable one cycle before and
  // after the transparent window, then pulse the ack once the latch is closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ack      <= '0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      grant_id <= '0;
      last     <= IDW'(NREQ - 1);
      cnt      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            latch_d  <= win_data;
            state    <= SETUP;
          end
        end
        SETUP: begin
          cnt      <= CW'(OPEN_CYC - 1);
          latch_en <= 1'b1;
          state    <= OPEN;
        end
        OPEN: begin
          if (cnt == '0) begin
            latch_en <= 1'b0;
            state    <= CLOSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CLOSE: begin
          ack   <= NREQ'(1) << grant_id;
          last  <= grant_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/latch_write_arbiter.md
Name: latch_write_arbiter

Overview:
- Round-robin arbiter and write sequencer that shares one WIRE-bit D-latch register between NREQ requesters.
- Drives the latch data and enable with a fixed setup/open/close sequence, so the latch input is never changed while the latch is transparent.
- Returns a one-cycle acknowledge to the requester whose data was latched.
- Sits between the requesting datapath blocks and the serial D-latch storage of the memory library.

Parameters:
- WIRE, 8, data width of the shared latch.
- NREQ, 4, number of requesters, at least 2.
- IDW, 2, width of the grant index; must equal ceil(log2(NREQ)).
- OPEN_CYC, 1, number of cycles latch_en is held high, at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request, level.
- data  input  NREQ*WIRE  flattened write data; requester i uses data[i*WIRE +: WIRE].
- ack  output  NREQ  one-hot, one-cycle pulse when requester's write is complete.
- latch_d  output  WIRE  data to the latch D input, registered.
- latch_en  output  1  latch enable (transparent when 1), registered.
- grant_id  output  IDW  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous; wins over everything):
  - state=IDLE; ack=0, latch_d=0, latch_en=0, grant_id=0, busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Reset asserted mid-transaction aborts it: no ack, latch_en low the next cycle.
- States are IDLE, SETUP, OPEN, CLOSE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first asserted req scanning last+1, last+2, ... modulo NREQ.
  - Register grant_id=winner and latch_d=data[winner]; go to SETUP.
- SETUP: latch_en=0 and latch_d stable for one cycle; load the open counter with OPEN_CYC-1; go to OPEN.
- OPEN:
  - latch_en=1 for exactly OPEN_CYC cycles; latch_d unchanged.
  - When the counter reaches 0, go to CLOSE.
- CLOSE:
  - latch_en=0; ack[grant_id]=1 for this cycle only; last=grant_id.
  - Go to IDLE.
- Timing:
  - Req sampled at edge N gives SETUP at N+1, OPEN at N+2..N+1+OPEN_CYC, and ack high in the cycle after edge N+2+OPEN_CYC.
  - With OPEN_CYC=1, ack is high 3 cycles after the sampling edge.
  - Minimum spacing between grants is OPEN_CYC+3 cycles.
- Data and request handling:
  - latch_d is captured only in IDLE. Changes on data or req during SETUP/OPEN/CLOSE are ignored.
  - A requester that drops req mid-transaction still gets its write completed and its ack pulsed.
  - req is level-sensitive and sampled only in IDLE. A requester holding req after its ack is treated as a new request, but round-robin serves any other pending requester first.
- Arbitration rules:
  - Simultaneous requests: exactly one grant per transaction; ack is never multi-hot.
  - Pointer wrap: after granting NREQ-1, the scan starts at 0.
  - A single requester holding req continuously gets back-to-back transactions with no starvation check needed.
- Invariants:
  - latch_en and a latch_d change are never asserted in the same cycle.
  - latch_en is never high in IDLE, SETUP or CLOSE.

Test Plan (WIRE=8, NREQ=4, OPEN_CYC=1 unless stated):
- Reset: hold reset 2 cycles with req=4'b1111 -> ack=0, latch_en=0, latch_d=0, busy=0 throughout; first grant after release is id 0.
- Single write: req=4'b0100, data lane2=8'hA5 -> SETUP with latch_d=A5; latch_en high exactly 1 cycle; ack=4'b0100 for 1 cycle 3 cycles after sampling; grant_id=2.
- Round robin: req=4'b1111 held, lanes 8'h10,8'h21,8'h32,8'h43 -> grants in order 0,1,2,3,0; latch_d sequence 10,21,32,43,10; one ack each, 4 cycles apart.
- Wrap and fairness: last grant 3, then req=4'b1001 -> next grant 0, then 3.
- Mid-transaction changes:
  - Change lane data and drop req during OPEN -> latch_d keeps the captured value; ack still pulses.
  - Assert reset in OPEN -> no ack; latch_en=0 the next cycle; state IDLE.
- OPEN_CYC=3: single write -> latch_en high exactly 3 consecutive cycles; ack 5 cycles after sampling.
